// File: rtl/aes128_key_expand_ctrl_pkg.sv
// Shared AES-128 key-schedule definitions: S-box table, GF(2^8) doubling,
// schedule constants and FSM state encodings.
package aes128_key_expand_ctrl_pkg;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam int unsigned AES_RK_NUM = 11;
  localparam int unsigned KEY_W      = 128;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_key_round_step.sv
// One AES-128 key-schedule round: derives round key i from round key i-1.
import aes128_key_expand_ctrl_pkg::*;

module aes128_key_round_step (
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0  = prev_key[127:96];
    w1  = prev_key[95:64];
    w2  = prev_key[63:32];
    w3  = prev_key[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_key_expand_ctrl.sv
// AES-128 key expansion controller: one round key per cycle into a
// register file of NR+1 keys, with combinational indexed read-out.
import aes128_key_expand_ctrl_pkg::*;

module aes128_key_expand_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  logic [0:0]       state;
  logic [3:0]       round;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] rk [0:NR];
  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;

  // The single step unit always works on the key written one round earlier.
  always_comb begin
    prev_key = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (round == 4'(i + 1)) prev_key = rk[i];
    end
  end

  aes128_key_round_step u_step (
    .prev_key (prev_key),
    .rcon     (rcon),
    .next_key (next_key)
  );

  // Indices beyond NR have no storage and read as zero.
  always_comb begin
    rd_key = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rd_key = rk[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round      <= '0;
      rcon       <= RCON_INIT;
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          rk[0]      <= key_in;
          round      <= 4'd1;
          rcon       <= RCON_INIT;
          keys_valid <= 1'b0;
          busy       <= 1'b1;
          state      <= ST_EXPAND;
        end
      end else begin
        for (int unsigned i = 1; i <= NR; i++) begin
          if (round == 4'(i)) rk[i] <= next_key;
        end
        rcon  <= xtime(rcon);
        round <= round + 4'd1;
        if (round == 4'(NR)) begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/aes128_key_expand_ctrl.md
AES128_KEY_EXPAND_CTRL -- requirements
Module: aes128_key_expand_ctrl

Interface
- REQ-001: Parameter NR, default 10: number of expansion rounds. Legal range 1..10; values below 10 give a truncated schedule for test only.
- REQ-002: clk  in  1  single clock; all state updates on rising edge.
- REQ-003: rst  in  1  synchronous, active-high reset.
- REQ-004: start  in  1  request expansion of key_in; sampled only in IDLE.
- REQ-005: key_in  in  128  cipher key; [127:96] is word w0, [31:0] is w3.
- REQ-006: busy  out  1  high while expansion is in progress.
- REQ-007: done  out  1  one-cycle pulse when the last round key is written.
- REQ-008: keys_valid  out  1  high while rk[0..NR] all hold the schedule of the last accepted key.
- REQ-009: rd_idx  in  4  round-key read index.
- REQ-010: rd_key  out  128  combinational read of rk[rd_idx]; 0 when rd_idx > NR.

Function
- REQ-011: Storage is 11 x 128-bit round-key registers rk[0..10], a 4-bit round counter and an 8-bit rcon register.
- REQ-012: FSM states are IDLE and EXPAND.
- REQ-013: IDLE with start=1 at edge E0:
  - rk[0] <= key_in; round <= 1; rcon <= 8'h01; keys_valid <= 0; busy <= 1; state -> EXPAND.
- REQ-014: EXPAND, each edge:
  - rk[round] <= step(rk[round-1], rcon); rcon <= xtime(rcon); round <= round+1.
  - Exactly one round per cycle.
- REQ-015: step(w, rc) is defined as:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - SubWord applies the AES S-box to each byte.
- REQ-016: xtime(r) = (r<<1) ^ (r[7] ? 8'h1B : 8'h00), truncated to 8 bits; the sequence is 01,02,04,08,10,20,40,80,1B,36.
- REQ-017: When rk[NR] is written (edge E_NR):
  - state -> IDLE; busy <= 0; keys_valid <= 1.
  - done is high for exactly the cycle following E_NR.
- REQ-018: Latency is NR cycles from start acceptance to done; busy is high for exactly NR cycles.
- REQ-019: start while busy=1 is ignored (no restart, no queuing).
- REQ-020: start on the same cycle done is high is accepted (IDLE), giving back-to-back expansions with no dead cycle.
- REQ-021: rk entries above NR are never written and read as 0 via rd_key.
- REQ-022: rd_key during EXPAND returns the current register contents; consumers shall gate on keys_valid.
- REQ-023: rk registers are not cleared by a new start except rk[0]; stale entries are masked by keys_valid=0.

Reset
- REQ-024: rst=1 at an edge forces:
  - state=IDLE; busy=0; done=0; keys_valid=0; round=0; rcon=8'h01; all rk=0.
- REQ-025: rst has priority over start and over an in-progress expansion; an aborted expansion leaves keys_valid=0.

Structure
- REQ-026: The shared package holds:
  - the S-box table function;
  - the xtime function;
  - constants RCON_INIT=8'h01, AES_RK_NUM=11, KEY_W=128.
- REQ-027: One combinational sub-module, aes128_key_round_step (inputs prev_key[127:0] and rcon[7:0], output next_key[127:0]), implements REQ-015. It is instantiated once and shared across rounds.

Verification
- REQ-028: FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - rk[1]=a0fafe1788542cb123a339392a6c7605;
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done exactly 10 cycles after acceptance;
  - busy high for 10 cycles.
- REQ-029: start reasserted on cycles 3..7 of an expansion:
  - schedule is unchanged and done fires once at cycle 10.
- REQ-030: rst asserted at cycle 5 of an expansion:
  - next cycle busy=0, keys_valid=0, rd_key(0)=0;
  - a new start afterwards completes with correct keys.
- REQ-031: Key all-zero, then start again with key all-FF in the done cycle:
  - the second expansion starts without gap;
  - the zero-key rk[10] is b4ef5bcb3e92e21123e951cf6f8f188e before being overwritten;
  - keys_valid drops for 10 cycles.
- REQ-032: After completion, sweep rd_idx 0..15:
  - indices 0..10 match the golden model;
  - indices 11..15 return 0.
- REQ-033: Random keys (>=1000) checked against the reference model, including rcon wrap through 80->1B->36.
